// File: rtl/cmd_encod_sched_if.sv
// Handshake bundle between the command-encoder scheduler and its requesters,
// the shared encoder mux and the error/status consumers.
interface cmd_encod_sched_if;
  logic       en;
  logic [3:0] req;
  logic       enc_done;
  logic       err_clr;
  logic [3:0] start_out;
  logic [3:0] ack;
  logic       busy;
  logic [1:0] chn;
  logic       timeout_err;
  logic [1:0] err_chn;

  // Requester / environment side
  modport master (
    output en, req, enc_done, err_clr,
    input  start_out, ack, busy, chn, timeout_err, err_chn
  );

  // Scheduler side
  modport slave (
    input  en, req, enc_done, err_clr,
    output start_out, ack, busy, chn, timeout_err, err_chn
  );
endinterface

// File: rtl/cmd_encod_sched.sv
// Round-robin scheduler granting one of four command sequence encoders at a
// time, with a watchdog that aborts a sequence whose done never arrives.
module cmd_encod_sched #(
  parameter int TO_BITS = 12
) (
  input logic              clk,
  input logic              rst_n,
  cmd_encod_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         last;
  logic [TO_BITS-1:0] wd;
  logic [TO_BITS-1:0] wd_next;
  logic [3:0]         start_q;
  logic [3:0]         ack_q;
  logic               busy_q;
  logic [1:0]         chn_q;
  logic               timeout_err_q;
  logic [1:0]         err_chn_q;
  logic [1:0]         winner;
  logic [1:0]         cand;
  logic               have_winner;

  // Search starts just after the last granted channel so every requester is
  // served within four grants.
  always_comb begin
    winner      = last;
    cand        = '0;
    have_winner = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!have_winner && bus.req[cand]) begin
        winner      = cand;
        have_winner = 1'b1;
      end
    end
  end

  assign wd_next = wd + TO_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last          <= 2'd3;
      wd            <= '0;
      start_q       <= '0;
      ack_q         <= '0;
      busy_q        <= 1'b0;
      chn_q         <= '0;
      timeout_err_q <= 1'b0;
      err_chn_q     <= '0;
    end else begin
      start_q <= '0;
      ack_q   <= '0;
      // Clear comes first so a timeout in the same cycle overrides it.
      if (bus.err_clr) begin
        timeout_err_q <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (bus.en && have_winner) begin
            chn_q   <= winner;
            last    <= winner;
            start_q <= 4'b0001 << winner;
            wd      <= '0;
            busy_q  <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.enc_done) begin
            ack_q <= 4'b0001 << chn_q;
            state <= ST_GAP;
          end else if (&wd_next) begin
            timeout_err_q <= 1'b1;
            err_chn_q     <= chn_q;
            state         <= ST_GAP;
          end else begin
            wd <= wd_next;
          end
        end
        ST_GAP: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.start_out   = start_q;
  assign bus.ack         = ack_q;
  assign bus.busy        = busy_q;
  assign bus.chn         = chn_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_chn     = err_chn_q;

endmodule

// File: tb/tb_cmd_encod_sched.sv
// Directed self-checking bench for cmd_encod_sched with a 4-bit watchdog
// (timeout after 15 RUN cycles).
module tb_cmd_encod_sched;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   cyc;
  int   prev_start;
  logic seen;
  logic excl_bad;

  cmd_encod_sched_if bus ();

  cmd_encod_sched #(.TO_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses must be one-hot and start/ack may never overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(bus.start_out) || !$onehot0(bus.ack) ||
          (bus.start_out != 4'b0 && bus.ack != 4'b0))
        excl_bad = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] req,
                               input logic done, input logic clr);
    bus.en       = en;
    bus.req      = req;
    bus.enc_done = done;
    bus.err_clr  = clr;
  endtask

  task automatic waitStart(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.start_out == 4'b0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_seen"}, 32'(bus.start_out != 4'b0), 32'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_start"}, 32'(bus.start_out), 32'd0);
    checkOutput({tag, "_ack"}, 32'(bus.ack), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_chn"}, 32'(bus.chn), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    excl_bad     = 1'b0;
    rst_n        = 1'b0;
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    checkIdleOutputs("rst");
    checkOutput("rst_terr", 32'(bus.timeout_err), 32'd0);
    checkOutput("rst_errchn", 32'(bus.err_chn), 32'd0);
    rst_n = 1'b1;
    repeat (7) tick();

    // Single request: grant one cycle later, ack one cycle after done.
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    tick();
    checkOutput("single_start", 32'(bus.start_out), 32'h1);
    checkOutput("single_busy", 32'(bus.busy), 32'd1);
    checkOutput("single_chn", 32'(bus.chn), 32'd0);
    tick();
    checkOutput("single_pulse_len", 32'(bus.start_out), 32'd0);
    repeat (11) tick();
    checkOutput("single_no_early_ack", 32'(bus.ack), 32'd0);
    bus.enc_done = 1'b1;
    tick();
    checkOutput("single_ack", 32'(bus.ack), 32'h1);
    checkOutput("single_busy_gap", 32'(bus.busy), 32'd1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("single_ack_len", 32'(bus.ack), 32'd0);
    checkOutput("single_busy_low", 32'(bus.busy), 32'd0);

    // Fairness from reset priority: 0,1,2,3,0 with 9-cycle spacing.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    prev_start = 0;
    for (int g = 0; g < 5; g++) begin
      waitStart("fair", 20);
      checkOutput("fair_grant", 32'(bus.start_out), 32'(1) << (g % 4));
      if (g > 0)
        checkOutput("fair_spacing", 32'(cyc - prev_start), 32'd9);
      prev_start = cyc;
      repeat (6) tick();
      bus.enc_done = 1'b1;
      tick();
      checkOutput("fair_ack", 32'(bus.ack), 32'(1) << (g % 4));
      bus.enc_done = 1'b0;
    end
    bus.req = 4'b0000;
    repeat (4) tick();

    // Watchdog: channel 2 never finishes.
    bus.req = 4'b0100;
    waitStart("wd", 10);
    checkOutput("wd_grant", 32'(bus.start_out), 32'h4);
    repeat (14) tick();
    checkOutput("wd_not_yet", 32'(bus.timeout_err), 32'd0);
    tick();
    checkOutput("wd_err", 32'(bus.timeout_err), 32'd1);
    checkOutput("wd_errchn", 32'(bus.err_chn), 32'd2);
    checkOutput("wd_no_ack", 32'(bus.ack), 32'd0);
    bus.req = 4'b1100;
    tick();
    checkOutput("wd_idle", 32'(bus.busy), 32'd0);
    waitStart("wd_next", 10);
    checkOutput("wd_next_grant", 32'(bus.start_out), 32'h8);
    checkOutput("wd_next_chn", 32'(bus.chn), 32'd3);
    bus.enc_done = 1'b1;
    tick();
    checkOutput("wd_next_ack", 32'(bus.ack), 32'h8);
    checkOutput("wd_sticky", 32'(bus.timeout_err), 32'd1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("wd_clr", 32'(bus.timeout_err), 32'd0);
    bus.err_clr = 1'b0;
    repeat (3) tick();

    // Done arriving on the terminal-count cycle wins over the timeout.
    bus.req = 4'b0100;
    waitStart("tc", 10);
    checkOutput("tc_grant", 32'(bus.start_out), 32'h4);
    repeat (14) tick();
    bus.enc_done = 1'b1;
    tick();
    checkOutput("tc_ack", 32'(bus.ack), 32'h4);
    checkOutput("tc_no_err", 32'(bus.timeout_err), 32'd0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("tc_no_err_later", 32'(bus.timeout_err), 32'd0);

    // Enable gating.
    applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (50) begin
      tick();
      seen = seen | (bus.start_out != 4'b0);
    end
    checkOutput("en_gated", 32'(seen), 32'd0);
    bus.en = 1'b1;
    tick();
    checkOutput("en_grant", 32'(bus.start_out), 32'h2);
    bus.en = 1'b0;
    repeat (3) tick();
    bus.enc_done = 1'b1;
    tick();
    checkOutput("en_off_ack", 32'(bus.ack), 32'h2);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    repeat (3) tick();

    // Reset during RUN returns everything to reset values, then re-grants.
    bus.req = 4'b0010;
    waitStart("rr", 10);
    checkOutput("rr_grant", 32'(bus.start_out), 32'h2);
    repeat (3) tick();
    checkOutput("rr_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("rr_async");
    tick();
    tick();
    checkIdleOutputs("rr_held");
    rst_n = 1'b1;
    waitStart("rr_regrant", 10);
    checkOutput("rr_regrant_val", 32'(bus.start_out), 32'h2);
    checkOutput("rr_regrant_chn", 32'(bus.chn), 32'd1);
    bus.enc_done = 1'b1;
    tick();
    checkOutput("rr_ack", 32'(bus.ack), 32'h2);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    repeat (3) tick();

    checkOutput("onehot_excl", 32'(excl_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
